// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 scan-code set 2 receiver with held-key bitmap for
// eight game keys (W S A D J K L SPACE).
// Optional feature macro: PS2_PARITY_CHECK_EN (odd-parity check on receive).
// Handshake: byte_valid and frame_err are single-cycle strobes with no ready;
// rx_byte and key are stable registers that change only with byte_valid.
// dbg_state / dbg_brk / dbg_ext expose receive FSM state and decoder flags.
module ps2_key_tracker #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [1:0] dbg_state,
    output logic       dbg_brk,
    output logic       dbg_ext
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        r_state, w_next;
    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_f;
    logic [FW-1:0] r_flt_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_key, r_rx_byte;
    logic          r_byte_valid, r_frame_err, r_brk, r_ext;
    logic          w_fall, w_timeout, w_accept;
    logic          w_start, w_shift_en, w_emit, w_err;
    logic [7:0]    w_mask;
`ifdef PS2_PARITY_CHECK_EN
    logic          r_parity;
    logic          w_par_en;
`endif

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock follows the synchronized clock only after FILTER_LEN
    // consecutive cycles at the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
        end else if (r_clk_s2 == r_clk_f) begin
            r_flt_cnt <= '0;
        end else if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
            r_clk_f   <= r_clk_s2;
            r_flt_cnt <= '0;
        end else begin
            r_flt_cnt <= r_flt_cnt + 1'b1;
        end
    end

    // The falling edge is flagged in the cycle the filtered clock drops.
    assign w_fall    = r_clk_f && !r_clk_s2 && (r_flt_cnt == FW'(FILTER_LEN - 1));
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT));

`ifdef PS2_PARITY_CHECK_EN
    assign w_accept = r_dat_s2 && (^{r_shift, r_parity});
`else
    assign w_accept = r_dat_s2;
`endif

    // Mid-frame inactivity counter; saturates at TIMEOUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (r_state == S_IDLE || w_fall)
            r_to_cnt <= '0;
        else if (r_to_cnt != TW'(TIMEOUT))
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Receive FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Receive FSM next-state and strobes.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_emit     = 1'b0;
        w_err      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        w_par_en   = 1'b0;
`endif
        if (w_timeout) begin
            w_next = S_IDLE;
            w_err  = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_s2) begin
                        w_next  = S_DATA;
                        w_start = 1'b1;
                    end
                end
                S_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_next = S_PARITY;
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    w_par_en = 1'b1;
`endif
                    w_next = S_STOP;
                end
                S_STOP: begin
                    w_next = S_IDLE;
                    if (w_accept) w_emit = 1'b1;
                    else          w_err  = 1'b1;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Shift register, bit counter and parity capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            if (w_start) r_bit_cnt <= 3'd0;
            if (w_shift_en) begin
                r_shift   <= {r_dat_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (w_par_en) r_parity <= r_dat_s2;
`endif
        end
    end

    // Scan-code to key-bit map.
    always_comb begin
        w_mask = 8'h00;
        case (r_shift)
            8'h1D: w_mask = 8'h80;
            8'h1B: w_mask = 8'h40;
            8'h1C: w_mask = 8'h20;
            8'h23: w_mask = 8'h10;
            8'h3B: w_mask = 8'h08;
            8'h42: w_mask = 8'h04;
            8'h4B: w_mask = 8'h02;
            8'h29: w_mask = 8'h01;
            default: w_mask = 8'h00;
        endcase
    end

    // Byte decoder: prefix flags, bitmap update and output strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key        <= 8'h00;
            r_rx_byte    <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_brk        <= 1'b0;
            r_ext        <= 1'b0;
        end else begin
            r_byte_valid <= w_emit;
            r_frame_err  <= w_err;
            if (w_emit) begin
                r_rx_byte <= r_shift;
                if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    if (!r_ext)
                        r_key <= r_brk ? (r_key & ~w_mask) : (r_key | w_mask);
                end
            end
        end
    end

    assign key        = r_key;
    assign rx_byte    = r_rx_byte;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;
    assign dbg_state  = r_state;
    assign dbg_brk    = r_brk;
    assign dbg_ext    = r_ext;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Testbench for ps2_key_tracker: directed PS/2 frames, expected events queued
// at issue time and checked by an independent monitor on byte_valid/frame_err.
module tb_ps2_key_tracker;

  localparam int TO = 1000;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  logic [1:0] dbg_state;
  logic       dbg_brk;
  logic       dbg_ext;

  // expected event: {is_err, rx_byte, key}
  logic [16:0] exp_q[$];
  logic [7:0]  last_rx;
  int          n_tests;
  int          n_fail;

  ps2_key_tracker #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key        (key),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state),
    .dbg_brk    (dbg_brk),
    .dbg_ext    (dbg_ext)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk);
    ps2_data = b;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
  endtask

  // full frame; pflip inverts the correct odd parity; glitch adds a short
  // low pulse on ps2_clk after data bit 3
  task automatic send_frame(input logic [7:0] b, input logic pflip,
                            input logic stop, input logic glitch);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (glitch && i == 3) begin
        wait_cyc(15);
        ps2_clk = 1'b0;
        wait_cyc(4);
        ps2_clk = 1'b1;
      end
    end
    send_bit(~(^b) ^ pflip);
    send_bit(stop);
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(i[0]);
    ps2_data = 1'b1;
  endtask

  task automatic push_ok(input logic [7:0] b, input logic [7:0] k);
    exp_q.push_back({1'b0, b, k});
    last_rx = b;
  endtask

  task automatic push_err(input logic [7:0] k);
    exp_q.push_back({1'b1, last_rx, k});
  endtask

  task automatic frame_ok(input logic [7:0] b, input logic [7:0] k);
    push_ok(b, k);
    send_frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  // monitor: pops one expected event per output strobe
  always @(negedge clk) begin
    if (!reset && (byte_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got bv=%0b fe=%0b rx=0x%0h key=0x%0h expected no event",
                 byte_valid, frame_err, rx_byte, key);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("evt_kind", {30'd0, byte_valid, frame_err}, e[16] ? 32'd1 : 32'd2);
        check("evt_rx_byte", {24'd0, rx_byte}, {24'd0, e[15:8]});
        check("evt_key", {24'd0, key}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    @(negedge clk);
    check({tag, "_key"}, {24'd0, key}, 32'd0);
    check({tag, "_rx"}, {24'd0, rx_byte}, 32'd0);
    check({tag, "_bv"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_fe"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
    check({tag, "_brk_ext"}, {30'd0, dbg_brk, dbg_ext}, 32'd0);
  endtask

  // stimulus
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    last_rx  = 8'h00;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    check_all_zero("reset");

    // make W
    frame_ok(8'h1D, 8'h80);
    // make D, break W
    frame_ok(8'h23, 8'h90);
    frame_ok(8'hF0, 8'h90);
    @(negedge clk);
    check("brk_set", {31'd0, dbg_brk}, 32'd1);
    frame_ok(8'h1D, 8'h10);
    @(negedge clk);
    check("brk_clear", {31'd0, dbg_brk}, 32'd0);

    // extended sequence is discarded
    frame_ok(8'hE0, 8'h10);
    @(negedge clk);
    check("ext_set", {31'd0, dbg_ext}, 32'd1);
    frame_ok(8'h1C, 8'h10);
    @(negedge clk);
    check("ext_clear", {31'd0, dbg_ext}, 32'd0);
    frame_ok(8'h1C, 8'h30);

    // bad stop bit
    push_err(8'h30);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);

    // bad parity
`ifdef PS2_PARITY_CHECK_EN
    push_err(8'h30);
`else
    push_ok(8'h29, 8'h31);
`endif
    send_frame(8'h29, 1'b1, 1'b1, 1'b0);
    frame_ok(8'hF0, (rx_byte == 8'h29) ? 8'h31 : 8'h30);
    frame_ok(8'h29, 8'h30);

    // timeout mid-frame
    push_err(8'h30);
    send_partial(4);
    wait_cyc(TO / 2);
    @(negedge clk);
    check("to_busy_state", {30'd0, dbg_state}, 32'd1);
    wait_cyc(TO / 2 + 100);
    @(negedge clk);
    check("to_idle_state", {30'd0, dbg_state}, 32'd0);
    frame_ok(8'h42, 8'h34);

    // short glitch on ps2_clk inside a frame
    push_ok(8'h4B, 8'h36);
    send_frame(8'h4B, 1'b0, 1'b1, 1'b1);
    // typematic repeat
    frame_ok(8'h4B, 8'h36);

    // reset mid-frame
    send_partial(3);
    @(posedge clk);
    reset = 1'b1;
    wait_cyc(3);
    check_all_zero("rst_mid");
    reset = 1'b0;
    wait_cyc(TO + 100);
    check_all_zero("rst_after");

    last_rx = 8'h00;
    frame_ok(8'h1D, 8'h80);

    wait_cyc(50);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
